// File: rtl/vram_tile_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vram_tile_arbiter
// Brief   : Shares the single-port tile-map RAM between VGA scan-out fetches
//           and game-logic req/ack accesses; presents the current tile code.
// Revision: 1.0 - initial release
// ============================================================================
module vram_tile_arbiter #(
    parameter int TW         = 4,
    parameter int H_PREFETCH = 700,
    parameter int H_LAST     = 789,
    parameter int V_LAST     = 523
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pix_en,
    input  logic [9:0]    hcount,
    input  logic [9:0]    vcount,
    output logic [10:0]   ram_addr,
    output logic          ram_we,
    output logic [TW-1:0] ram_wdata,
    input  logic [TW-1:0] ram_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [10:0]   cpu_addr,
    input  logic [TW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [TW-1:0] cpu_rdata,
    output logic [TW-1:0] tile_code
);

    localparam logic [9:0]  H_PREFETCH_V = 10'(H_PREFETCH);
    localparam logic [9:0]  H_LAST_V     = 10'(H_LAST);
    localparam logic [9:0]  V_LAST_V     = 10'(V_LAST);
    localparam logic [10:0] MAP_DEPTH    = 11'd1200;

    // CPU_NODATA covers writes and out-of-range reads: both return zero data.
    typedef enum logic [1:0] {
        TAG_NONE       = 2'd0,
        TAG_DISP       = 2'd1,
        TAG_CPU_RD     = 2'd2,
        TAG_CPU_NODATA = 2'd3
    } tag_t;

    logic [9:0]  w_next_line;
    logic        w_mid_fetch;
    logic        w_line_fetch;
    logic        w_disp_fetch;
    logic [5:0]  w_row;
    logic [5:0]  w_col;
    logic [10:0] w_disp_addr;
    logic        w_cpu_in_range;
    logic        w_tile_load;

    logic [10:0]   ram_addr_q,  ram_addr_d;
    logic          ram_we_q,    ram_we_d;
    logic [TW-1:0] ram_wdata_q, ram_wdata_d;
    tag_t          tag1_q,      tag1_d;
    tag_t          tag2_q,      tag2_d;
    logic [TW-1:0] next_tile_q, next_tile_d;
    logic          cpu_busy_q,  cpu_busy_d;
    logic          cpu_ack_q,   cpu_ack_d;
    logic [TW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [TW-1:0] tile_code_q, tile_code_d;

    always_comb begin
        w_next_line  = (vcount == V_LAST_V) ? 10'd0 : vcount + 10'd1;
        w_mid_fetch  = pix_en && (hcount[3:0] == 4'd8) && (hcount < 10'd624)
                       && (vcount < 10'd480);
        w_line_fetch = pix_en && (hcount == H_PREFETCH_V) && (w_next_line < 10'd480);
        w_disp_fetch = w_mid_fetch || w_line_fetch;
        if (w_mid_fetch) begin
            w_row = vcount[9:4];
            w_col = hcount[9:4] + 6'd1;
        end else begin
            w_row = w_next_line[9:4];
            w_col = 6'd0;
        end
        // row*40 + col without a multiplier
        w_disp_addr    = ({5'd0, w_row} << 5) + ({5'd0, w_row} << 3) + {5'd0, w_col};
        w_cpu_in_range = (cpu_addr < MAP_DEPTH);
        w_tile_load    = pix_en && (((hcount[3:0] == 4'hF) && (hcount < 10'd639))
                                    || (hcount == H_LAST_V));
    end

    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        tag1_d      = TAG_NONE;
        tag2_d      = tag1_q;
        next_tile_d = next_tile_q;
        cpu_busy_d  = cpu_busy_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        tile_code_d = tile_code_q;

        // Retire: RAM data belonging to the stage-2 tag is on ram_rdata now.
        case (tag2_q)
            TAG_DISP: next_tile_d = ram_rdata;
            TAG_CPU_RD: begin
                cpu_rdata_d = ram_rdata;
                cpu_ack_d   = 1'b1;
                cpu_busy_d  = 1'b0;
            end
            TAG_CPU_NODATA: begin
                cpu_rdata_d = '0;
                cpu_ack_d   = 1'b1;
                cpu_busy_d  = 1'b0;
            end
            default: ;
        endcase

        // Issue: display fetches always own the port on their edge.
        if (w_disp_fetch) begin
            ram_addr_d = w_disp_addr;
            tag1_d     = TAG_DISP;
        end else if (cpu_req && !cpu_busy_q) begin
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            ram_we_d    = cpu_we && w_cpu_in_range;
            tag1_d      = (cpu_we || !w_cpu_in_range) ? TAG_CPU_NODATA : TAG_CPU_RD;
            cpu_busy_d  = 1'b1;
        end

        if (w_tile_load) begin
            tile_code_d = next_tile_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            next_tile_q <= '0;
            cpu_busy_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            tile_code_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            next_tile_q <= next_tile_d;
            cpu_busy_q  <= cpu_busy_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            tile_code_q <= tile_code_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign tile_code = tile_code_q;

endmodule
`default_nettype wire

// File: doc/vram_tile_arbiter.md
Name: vram_tile_arbiter

Overview:
- Shares one single-port synchronous tile-map RAM between the VGA scan-out path and the game-logic port.
- The map is 40x30 tiles of 16x16 pixels, 1200 entries deep, with 1-cycle read latency.
- Display fetches are scheduled from the sync counters and always win the RAM port; game reads and writes fill the remaining cycles through a req/ack handshake.
- The block delivers the current tile code aligned to hcount, for the pixel/colour stage.

Parameters:
- TW, 4, tile code width in bits.
- H_PREFETCH, 700, hcount at which column 0 of the next line is fetched.
- H_LAST, 789, hcount value at line wrap, where hcount returns to 0.
- V_LAST, 523, vcount value at frame wrap, where vcount returns to 0.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel enable, high every 2nd clk; counters advance on edges where it is high.
- hcount  in  10  current pixel column.
- vcount  in  10  current line.
- ram_addr  out  11  RAM address (registered).
- ram_we  out  1  RAM write strobe (registered).
- ram_wdata  out  TW  RAM write data (registered).
- ram_rdata  in  TW  RAM read data, valid the cycle after the address is sampled.
- cpu_req  in  1  game access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; held with cpu_req.
- cpu_addr  in  11  linear tile index (row*40+col); held with cpu_req.
- cpu_wdata  in  TW  write data; held with cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  TW  read result, valid while cpu_ack is high.
- tile_code  out  TW  tile under the current hcount/vcount.

Behaviour:
- Reset (async, reset_n low) clears every register and output to 0:
  - ram_addr, ram_we, ram_wdata, cpu_ack, cpu_rdata, tile_code.
  - next_tile, the pipeline tags, and cpu_busy.
  - In-flight accesses are dropped; no ack is issued for them.
- Display trigger D at edge E (requires pix_en=1):
  - Mid-line fetch: hcount[3:0]==8, hcount<624, vcount<480. Fetches col = hcount[9:4]+1, row = vcount[9:4].
  - Next-line fetch: hcount==H_PREFETCH. Next line nl = 0 if vcount==V_LAST, else vcount+1. Fetch happens only if nl<480; col = 0, row = nl[9:4].
  - Address = row*32 + row*8 + col. Shift-add only, 11-bit, max 1199.
- Arbitration, evaluated at every edge:
  - If D: register the display address, ram_we=0, push tag DISP.
  - Else if cpu_req and not cpu_busy: register cpu_addr, cpu_we, cpu_wdata; push tag CPU; set cpu_busy.
  - Else: ram_we=0, push tag NONE.
  - ram_we is high for exactly one cycle per write.
- Two-stage tag pipeline:
  - The tag issued at edge G reaches stage 2 at edge G+1; ram_rdata is captured at edge G+2.
  - DISP: next_tile <= ram_rdata.
  - CPU: cpu_rdata <= ram_rdata (0 for writes); cpu_ack pulses high for the one cycle following G+2; cpu_busy clears at that same edge.
  - Next CPU grant is possible at G+3 at the earliest. Requester lowers cpu_req in the ack cycle or issues a fresh request.
- Out-of-range CPU address (cpu_addr>=1200): still granted, but ram_we is forced 0, and cpu_ack is given with cpu_rdata=0.
- Display has absolute priority. Worst-case CPU wait is 1 cycle, because D fires at most once per 32 clk and never on 2 consecutive edges.
- tile_code update, on pix_en edges only:
  - tile_code <= next_tile when (hcount[3:0]==15 and hcount<639), or hcount==H_LAST.
  - tile_code therefore changes at the same edge hcount enters the new tile.
  - During blanking tile_code is don't-care but must be stable.
- The frame wrap (vcount==V_LAST) prefetches row 0 col 0 at H_PREFETCH.
- The RAM data margin (D edge + 2 < load edge) is guaranteed by the trigger positions.

Test Plan:
1. Reset release; preload RAM index 0..39 with i mod 16; run one line at vcount=0 → tile_code equals i mod 16 for hcount 16i..16i+15, i=0..39. Zero RAM-port collisions.
2. CPU write (cpu_we=1, cpu_addr=41, cpu_wdata=0xA) while idle → ram_we high for exactly 1 cycle with addr 41; cpu_ack 3 cycles after grant. Subsequent read of 41 → cpu_rdata=0xA with ack.
3. Assert cpu_req on the exact edge of a display trigger (hcount=8, pix_en=1) → display address issued first; CPU granted the next edge; ack one cycle later than case 2.
4. cpu_addr=1200 write of 0xF → ram_we never asserted, cpu_ack still pulses, cpu_rdata=0. RAM contents unchanged.
5. vcount=V_LAST, hcount=H_PREFETCH with RAM[0]=0x7 → ram_addr=0 issued; tile_code=0x7 when hcount wraps at H_LAST into vcount=0. vcount=478→479 boundary: the prefetch at vcount 479 is suppressed (nl=480).
6. Deassert reset_n between a CPU grant and its ack → all outputs 0 immediately; no cpu_ack after release. A re-issued request completes normally.
